mem_arb: RTL and testbench
==========================

Name: mem_arb

Overview:
- Arbiter and sequencer for the single shared 32-bit memory port of the SISC processor.
- It multiplexes the instruction-fetch requester (IF) and the load/store requester (DM) onto one memory.
- It runs a per-access handshake FSM with a variable-latency ack, a fetch anti-starvation counter and a timeout watchdog.
- It sits between the fetch/ctrl logic and the memory model at the sisc top level.

Parameters:
AW, 16, address width
DW, 32, data width
STARVE_MAX, 4, consecutive fetch losses before fetch is forced to win (range 1..15)
TMO_CYC, 16, BUSY cycles without mem_ack before the access is aborted (range 2..255)

Ports:
clk  in  1  system clock, rising edge
rst_f  in  1  asynchronous active-low reset
if_req  in  1  fetch request, level; if_addr stable while high
if_addr  in  AW  fetch word address
if_gnt  out  1  one-cycle pulse: fetch request accepted
if_rvalid  out  1  one-cycle pulse: if_rdata valid
if_rdata  out  DW  fetched instruction
dm_req  in  1  data request, level; dm_addr/dm_we/dm_wdata stable while high
dm_we  in  1  1=store, 0=load
dm_addr  in  AW  data word address
dm_wdata  in  DW  store data
dm_gnt  out  1  one-cycle pulse: data request accepted
dm_rvalid  out  1  one-cycle pulse: completion (load data, or store done)
dm_rdata  out  DW  load data; 0 on store completion
err  out  1  pulses with rvalid when the access timed out
mem_req  out  1  memory access in progress
mem_we  out  1  write strobe, qualified by mem_req
mem_addr  out  AW  latched access address
mem_wdata  out  DW  latched store data
mem_rdata  in  DW  memory read data, valid with mem_ack
mem_ack  in  1  memory completion, sampled while mem_req=1

Behaviour:
- FSM states: IDLE, BUSY, RESP. All outputs are registered.
- Reset (rst_f=0, asynchronous):
  - State goes to IDLE.
  - Every output is 0, including mem_addr, mem_wdata and the rdata buses.
  - The starvation and timeout counters are 0.
  - Reset mid-access drops mem_req immediately. No rvalid is produced for the aborted access.
- Arbitration runs at a rising edge in IDLE or RESP when if_req or dm_req is high:
  - Only one requesting: that one wins.
  - Both requesting and starve_cnt < STARVE_MAX: DM wins and starve_cnt increments.
  - Both requesting and starve_cnt == STARVE_MAX: IF wins.
  - starve_cnt clears whenever IF wins.
- Win edge:
  - Latch the address, and for DM also we/wdata, into the mem_* registers.
  - Record the owner. Clear tmo_cnt. Go to BUSY.
  - During the next cycle: owner gnt=1 and mem_req=1.
  - The requester may drop req or change address after the gnt cycle. If its req is still high at the next arbitration, that is a new access.
- BUSY:
  - mem_req stays 1; mem_addr, mem_we and mem_wdata stay constant.
  - Edge with mem_ack=1: capture mem_rdata (0 for stores) into the owner's rdata. Go to RESP.
  - Edge with mem_ack=0: tmo_cnt increments.
  - When tmo_cnt reaches TMO_CYC-1 without ack: go to RESP with rdata=0 and err=1.
- RESP:
  - Owner rvalid=1 for exactly one cycle; err is qualified by rvalid. mem_req=0.
  - Arbitrates the same edge, going to BUSY or IDLE. No idle bubble is required.
- Latency with zero-wait memory (ack in the first BUSY cycle):
  - req high at edge N -> gnt/mem_req during cycle N+1 -> rvalid during cycle N+2.
  - Back-to-back throughput is one access per 2 cycles.
- rdata holds until the owner's next rvalid. The non-owner's rdata is unchanged.
- mem_ack outside BUSY is ignored.
- Simultaneous new requests at the RESP edge follow the same priority rules.

Decomposition:
- Shared package: state encoding (IDLE/BUSY/RESP), owner encoding (OWN_IF/OWN_DM), default AW/DW.
- Sub-module arb_pick: combinational winner select plus starve_cnt register. The FSM and datapath latches stay in mem_arb.

Test Plan:
- Single fetch, zero-wait: if_req=1, if_addr=0x0010, mem_rdata=0x8800_0001 with immediate ack -> if_gnt in cycle N+1, mem_addr=0x0010, mem_we=0, if_rvalid with if_rdata=0x8800_0001 in cycle N+2, err=0.
- Store then load with 3-cycle ack delay:
  - Store: dm_we=1, addr 0x0020, wdata 0xDEAD_BEEF -> mem_we=1 and mem_req held 3 cycles; dm_rvalid with dm_rdata=0.
  - Load of 0x0020 from memory model -> dm_rdata=0xDEAD_BEEF.
- Contention/starvation, STARVE_MAX=4, both req held continuously:
  - Grant order DM,DM,DM,DM,IF,DM,DM,DM,DM,IF.
  - starve_cnt observed 0 after each IF grant.
- Timeout, TMO_CYC=16: mem_ack tied 0, dm load -> after 16 BUSY cycles dm_rvalid=1, err=1, dm_rdata=0; next request proceeds normally.
- Reset mid-access: assert rst_f=0 in BUSY -> mem_req falls without waiting for clk, no rvalid ever issued, all outputs 0; after release, if_req serviced normally.
- Back-to-back: if_req held high at addresses 0x0,0x1,0x2 with zero-wait memory -> if_rvalid every 2nd cycle with matching data, no IDLE visits.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the SISC memory-port arbiter.
// Holds the FSM state encoding, the access-owner encoding and the
// default bus widths used by mem_arb and its arb_pick sub-module.
package mem_arb_pkg;

  localparam int unsigned DEF_AW = 16;
  localparam int unsigned DEF_DW = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_DM = 1'b1
  } owner_e;

endpackage

// File: rtl/mem_arb_pick.sv
// Winner select for the shared memory port plus the fetch anti-starvation
// counter. The winner is purely combinational from the two request levels
// and the counter; the counter only moves on edges where an arbitration
// actually happens (arb_en high).
//
// Ports:
//   clk, rst_f          clock, asynchronous active-low reset
//   arb_en              the FSM is in a state that accepts a new access
//   if_req, dm_req      request levels from fetch and load/store
//   win_valid           some requester wins at this edge
//   win_owner           which requester wins (valid with win_valid)
module arb_pick
  import mem_arb_pkg::*;
#(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic   clk,
  input  logic   rst_f,
  input  logic   arb_en,
  input  logic   if_req,
  input  logic   dm_req,
  output logic   win_valid,
  output owner_e win_owner
);

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  logic [3:0] starve_q, starve_d;

  // Data accesses normally beat fetches, but after STARVE_MAX consecutive
  // contended losses the fetch is forced through. Any fetch win restarts
  // the count; an uncontended data win leaves it alone.
  always_comb begin
    win_valid = arb_en & (if_req | dm_req);
    win_owner = OWN_IF;
    starve_d  = starve_q;
    if (arb_en) begin
      if (if_req && dm_req) begin
        if (starve_q < STARVE_LIM) begin
          win_owner = OWN_DM;
          starve_d  = starve_q + 4'd1;
        end else begin
          win_owner = OWN_IF;
          starve_d  = 4'd0;
        end
      end else if (if_req) begin
        win_owner = OWN_IF;
        starve_d  = 4'd0;
      end else if (dm_req) begin
        win_owner = OWN_DM;
      end
    end
  end

  // Starvation counter register.
  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      starve_q <= 4'd0;
    end else begin
      starve_q <= starve_d;
    end
  end

endmodule

// File: rtl/mem_arb.sv
// Arbiter and sequencer for the single shared memory port of the SISC core.
// Multiplexes instruction fetch (IF) and load/store (DM) onto one memory,
// runs an IDLE/BUSY/RESP handshake per access with a variable-latency ack,
// and aborts an access that sees no ack for TMO_CYC BUSY cycles. All outputs
// are registered.
//
// Ports:
//   clk, rst_f                     clock, asynchronous active-low reset
//   if_req/if_addr                 fetch request level and word address
//   if_gnt/if_rvalid/if_rdata      fetch accept pulse, completion pulse, data
//   dm_req/dm_we/dm_addr/dm_wdata  data request, store flag, address, data
//   dm_gnt/dm_rvalid/dm_rdata      data accept pulse, completion pulse, data
//   err                            timeout flag, qualified by an rvalid
//   mem_req/mem_we/mem_addr/mem_wdata  memory-side access registers
//   mem_rdata/mem_ack              memory read data and completion
module mem_arb
  import mem_arb_pkg::*;
#(
  parameter int unsigned AW         = DEF_AW,
  parameter int unsigned DW         = DEF_DW,
  parameter int unsigned STARVE_MAX = 4,
  parameter int unsigned TMO_CYC    = 16
) (
  input  logic          clk,
  input  logic          rst_f,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_gnt,
  output logic          if_rvalid,
  output logic [DW-1:0] if_rdata,
  input  logic          dm_req,
  input  logic          dm_we,
  input  logic [AW-1:0] dm_addr,
  input  logic [DW-1:0] dm_wdata,
  output logic          dm_gnt,
  output logic          dm_rvalid,
  output logic [DW-1:0] dm_rdata,
  output logic          err,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ack
);

  localparam logic [7:0] TMO_LAST = 8'(TMO_CYC - 1);

  state_e        state_q, state_d;
  owner_e        owner_q, owner_d;
  logic [7:0]    tmo_q, tmo_d;

  logic          if_gnt_q, if_gnt_d;
  logic          dm_gnt_q, dm_gnt_d;
  logic          if_rvalid_q, if_rvalid_d;
  logic          dm_rvalid_q, dm_rvalid_d;
  logic [DW-1:0] if_rdata_q, if_rdata_d;
  logic [DW-1:0] dm_rdata_q, dm_rdata_d;
  logic          err_q, err_d;
  logic          mem_req_q, mem_req_d;
  logic          mem_we_q, mem_we_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic [DW-1:0] resp_data;

  logic          arb_en;
  logic          win_valid;
  owner_e        win_owner;

  // A new access can start from IDLE, or from RESP in the same edge that
  // retires the previous one, which gives one access per two cycles.
  assign arb_en = (state_q == ST_IDLE) || (state_q == ST_RESP);

  arb_pick #(
    .STARVE_MAX (STARVE_MAX)
  ) u_pick (
    .clk       (clk),
    .rst_f     (rst_f),
    .arb_en    (arb_en),
    .if_req    (if_req),
    .dm_req    (dm_req),
    .win_valid (win_valid),
    .win_owner (win_owner)
  );

  // State register together with every registered output. Reset clears the
  // whole lot at once, so an access in flight loses mem_req immediately and
  // never produces a completion pulse.
  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      state_q     <= ST_IDLE;
      owner_q     <= OWN_IF;
      tmo_q       <= 8'd0;
      if_gnt_q    <= 1'b0;
      dm_gnt_q    <= 1'b0;
      if_rvalid_q <= 1'b0;
      dm_rvalid_q <= 1'b0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
      err_q       <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      tmo_q       <= tmo_d;
      if_gnt_q    <= if_gnt_d;
      dm_gnt_q    <= dm_gnt_d;
      if_rvalid_q <= if_rvalid_d;
      dm_rvalid_q <= dm_rvalid_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
      err_q       <= err_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  // Next-state logic. The timeout fires on the edge that closes the
  // TMO_CYC-th BUSY cycle without an ack; an ack on that same edge wins.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    tmo_d   = tmo_q;
    case (state_q)
      ST_IDLE, ST_RESP: begin
        if (win_valid) begin
          state_d = ST_BUSY;
          owner_d = win_owner;
          tmo_d   = 8'd0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (mem_ack) begin
          state_d = ST_RESP;
        end else if (tmo_q == TMO_LAST) begin
          state_d = ST_RESP;
        end else begin
          tmo_d = tmo_q + 8'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output logic: values the output registers take at the coming edge.
  // Stores and timeouts complete with zero data; the non-owner's rdata
  // and the memory-side registers simply hold.
  always_comb begin
    if_gnt_d    = 1'b0;
    dm_gnt_d    = 1'b0;
    if_rvalid_d = 1'b0;
    dm_rvalid_d = 1'b0;
    err_d       = 1'b0;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_req_d   = (state_d == ST_BUSY);
    resp_data   = (mem_ack && !mem_we_q) ? mem_rdata : '0;
    case (state_q)
      ST_IDLE, ST_RESP: begin
        if (win_valid) begin
          if (win_owner == OWN_DM) begin
            dm_gnt_d    = 1'b1;
            mem_addr_d  = dm_addr;
            mem_we_d    = dm_we;
            mem_wdata_d = dm_wdata;
          end else begin
            if_gnt_d    = 1'b1;
            mem_addr_d  = if_addr;
            mem_we_d    = 1'b0;
          end
        end
      end
      ST_BUSY: begin
        if (state_d == ST_RESP) begin
          err_d = ~mem_ack;
          if (owner_q == OWN_DM) begin
            dm_rvalid_d = 1'b1;
            dm_rdata_d  = resp_data;
          end else begin
            if_rvalid_d = 1'b1;
            if_rdata_d  = resp_data;
          end
        end
      end
      default: ;
    endcase
  end

  assign if_gnt    = if_gnt_q;
  assign dm_gnt    = dm_gnt_q;
  assign if_rvalid = if_rvalid_q;
  assign dm_rvalid = dm_rvalid_q;
  assign if_rdata  = if_rdata_q;
  assign dm_rdata  = dm_rdata_q;
  assign err       = err_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_arb.sv
// Directed self-checking bench for mem_arb. Inputs change and outputs are
// sampled on the falling clock edge; a small memory model answers reads
// from a fixed table plus one remembered store.
module tb_mem_arb;

  logic        clk;
  logic        rst_f;
  logic        if_req;
  logic [15:0] if_addr;
  logic        if_gnt;
  logic        if_rvalid;
  logic [31:0] if_rdata;
  logic        dm_req;
  logic        dm_we;
  logic [15:0] dm_addr;
  logic [31:0] dm_wdata;
  logic        dm_gnt;
  logic        dm_rvalid;
  logic [31:0] dm_rdata;
  logic        err;
  logic        mem_req;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  int checks = 0;
  int errors = 0;

  // Memory model state: one remembered store on top of a fixed read table.
  logic        st_valid = 1'b0;
  logic [15:0] st_addr  = 16'h0;
  logic [31:0] st_data  = 32'h0;

  mem_arb #(
    .AW         (16),
    .DW         (32),
    .STARVE_MAX (4),
    .TMO_CYC    (16)
  ) dut (
    .clk       (clk),
    .rst_f     (rst_f),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_gnt    (if_gnt),
    .if_rvalid (if_rvalid),
    .if_rdata  (if_rdata),
    .dm_req    (dm_req),
    .dm_we     (dm_we),
    .dm_addr   (dm_addr),
    .dm_wdata  (dm_wdata),
    .dm_gnt    (dm_gnt),
    .dm_rvalid (dm_rvalid),
    .dm_rdata  (dm_rdata),
    .err       (err),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack)
  );

  // 10-time-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory read table; a remembered store overrides its address.
  always_comb begin
    case (mem_addr)
      16'h0000: mem_rdata = 32'hA000_0000;
      16'h0001: mem_rdata = 32'hA000_0001;
      16'h0002: mem_rdata = 32'hA000_0002;
      16'h0010: mem_rdata = 32'h8800_0001;
      default:  mem_rdata = {16'hCC00, mem_addr};
    endcase
    if (st_valid && (mem_addr == st_addr)) mem_rdata = st_data;
  end

  // Stores take effect on the acknowledging edge.
  always @(posedge clk) begin
    if (mem_req && mem_we && mem_ack) begin
      st_valid <= 1'b1;
      st_addr  <= mem_addr;
      st_data  <= mem_wdata;
    end
  end

  // Safety net so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] simulation did not finish");
  end

  // Advance one full cycle and land on the next falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Drive every requester-side and memory-side input in one go.
  task automatic applyStimulus(input logic ifr, input logic [15:0] ifa,
                               input logic dmr, input logic dmw,
                               input logic [15:0] dma, input logic [31:0] dmd,
                               input logic ack);
    if_req   = ifr;
    if_addr  = ifa;
    dm_req   = dmr;
    dm_we    = dmw;
    dm_addr  = dma;
    dm_wdata = dmd;
    mem_ack  = ack;
  endtask

  // One comparison point.
  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  logic [9:0] exp_if_order;
  logic       exp_if;

  initial begin
    // ---- reset state ----
    rst_f = 1'b0;
    applyStimulus(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 32'h0, 1'b0);
    step();
    checkOutput("rst_ctrl", {25'b0, if_gnt, if_rvalid, dm_gnt, dm_rvalid, err, mem_req, mem_we}, 32'h0);
    checkOutput("rst_addr", {16'b0, mem_addr}, 32'h0);
    checkOutput("rst_wdata", mem_wdata, 32'h0);
    checkOutput("rst_if_rdata", if_rdata, 32'h0);
    checkOutput("rst_dm_rdata", dm_rdata, 32'h0);
    rst_f = 1'b1;
    step();

    // ---- single fetch, zero-wait ----
    applyStimulus(1'b1, 16'h0010, 1'b0, 1'b0, 16'h0, 32'h0, 1'b1);
    step();
    checkOutput("f1_gnt", {29'b0, if_gnt, dm_gnt, mem_req}, 32'h5);
    checkOutput("f1_addr", {16'b0, mem_addr}, 32'h0010);
    checkOutput("f1_we", {31'b0, mem_we}, 32'h0);
    if_req = 1'b0;
    step();
    checkOutput("f1_rvalid", {28'b0, if_rvalid, dm_rvalid, err, mem_req}, 32'h8);
    checkOutput("f1_rdata", if_rdata, 32'h8800_0001);
    step();
    checkOutput("f1_rvalid_pulse", {31'b0, if_rvalid}, 32'h0);
    checkOutput("f1_rdata_hold", if_rdata, 32'h8800_0001);

    // ---- store with 3-cycle ack delay ----
    applyStimulus(1'b0, 16'h0, 1'b1, 1'b1, 16'h0020, 32'hDEAD_BEEF, 1'b0);
    step();
    checkOutput("st_gnt", {29'b0, dm_gnt, mem_req, mem_we}, 32'h7);
    checkOutput("st_wdata", mem_wdata, 32'hDEAD_BEEF);
    dm_req = 1'b0;
    step();
    checkOutput("st_busy2", {28'b0, dm_gnt, mem_req, mem_we, dm_rvalid}, 32'h6);
    step();
    checkOutput("st_busy3", {29'b0, mem_req, mem_we, dm_rvalid}, 32'h6);
    mem_ack = 1'b1;
    step();
    checkOutput("st_done", {28'b0, dm_rvalid, err, mem_req, if_rvalid}, 32'h8);
    checkOutput("st_rdata", dm_rdata, 32'h0);
    checkOutput("st_if_rdata_kept", if_rdata, 32'h8800_0001);

    // ---- load back the stored word, arbitrated at the RESP edge ----
    applyStimulus(1'b0, 16'h0, 1'b1, 1'b0, 16'h0020, 32'h0, 1'b0);
    step();
    checkOutput("ld_gnt", {29'b0, dm_gnt, mem_req, mem_we}, 32'h6);
    dm_req = 1'b0;
    step();
    step();
    mem_ack = 1'b1;
    step();
    checkOutput("ld_done", {30'b0, dm_rvalid, err}, 32'h2);
    checkOutput("ld_rdata", dm_rdata, 32'hDEAD_BEEF);
    mem_ack = 1'b0;
    step();

    // ---- contention / starvation ----
    exp_if_order = 10'b10_0001_0000;
    applyStimulus(1'b1, 16'h0001, 1'b1, 1'b0, 16'h0002, 32'h0, 1'b1);
    for (int i = 0; i < 10; i++) begin
      exp_if = exp_if_order[i];
      step();
      checkOutput($sformatf("starve_gnt%0d", i), {30'b0, if_gnt, dm_gnt}, {30'b0, exp_if, ~exp_if});
      if (exp_if) begin
        checkOutput($sformatf("starve_cnt%0d", i), {28'b0, dut.u_pick.starve_q}, 32'h0);
      end
      step();
      if (i == 9) begin
        if_req = 1'b0;
        dm_req = 1'b0;
      end
    end
    mem_ack = 1'b0;
    step();

    // ---- timeout ----
    applyStimulus(1'b0, 16'h0, 1'b1, 1'b0, 16'h0005, 32'h0, 1'b0);
    step();
    checkOutput("tmo_gnt", {30'b0, dm_gnt, mem_req}, 32'h3);
    dm_req = 1'b0;
    for (int c = 2; c <= 16; c++) begin
      step();
      checkOutput($sformatf("tmo_busy%0d", c), {29'b0, mem_req, dm_rvalid, err}, 32'h4);
    end
    step();
    checkOutput("tmo_done", {29'b0, dm_rvalid, err, mem_req}, 32'h6);
    checkOutput("tmo_rdata", dm_rdata, 32'h0);
    applyStimulus(1'b1, 16'h0010, 1'b0, 1'b0, 16'h0, 32'h0, 1'b1);
    step();
    checkOutput("tmo_next_gnt", {30'b0, if_gnt, mem_req}, 32'h3);
    if_req = 1'b0;
    step();
    checkOutput("tmo_next_done", {30'b0, if_rvalid, err}, 32'h2);
    checkOutput("tmo_next_rdata", if_rdata, 32'h8800_0001);
    step();

    // ---- reset in the middle of an access ----
    applyStimulus(1'b1, 16'h0001, 1'b0, 1'b0, 16'h0, 32'h0, 1'b0);
    step();
    checkOutput("mr_gnt", {30'b0, if_gnt, mem_req}, 32'h3);
    if_req = 1'b0;
    step();
    #2 rst_f = 1'b0;
    #1;
    checkOutput("mr_async", {31'b0, mem_req}, 32'h0);
    checkOutput("mr_ctrl", {25'b0, if_gnt, if_rvalid, dm_gnt, dm_rvalid, err, mem_req, mem_we}, 32'h0);
    checkOutput("mr_rdata", if_rdata | dm_rdata, 32'h0);
    checkOutput("mr_addr", {16'b0, mem_addr}, 32'h0);
    mem_ack = 1'b1;
    step();
    checkOutput("mr_held", {29'b0, if_rvalid, dm_rvalid, mem_req}, 32'h0);
    rst_f = 1'b1;
    mem_ack = 1'b0;
    step();
    checkOutput("mr_no_rvalid", {29'b0, if_rvalid, dm_rvalid, mem_req}, 32'h0);
    applyStimulus(1'b1, 16'h0010, 1'b0, 1'b0, 16'h0, 32'h0, 1'b1);
    step();
    checkOutput("mr_after_gnt", {30'b0, if_gnt, mem_req}, 32'h3);
    if_req = 1'b0;
    step();
    checkOutput("mr_after_done", {30'b0, if_rvalid, err}, 32'h2);
    checkOutput("mr_after_rdata", if_rdata, 32'h8800_0001);
    step();

    // ---- back-to-back fetches, one every two cycles ----
    applyStimulus(1'b1, 16'h0000, 1'b0, 1'b0, 16'h0, 32'h0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step();
      checkOutput($sformatf("b2b_gnt%0d", i), {29'b0, if_gnt, mem_req, if_rvalid}, 32'h6);
      checkOutput($sformatf("b2b_addr%0d", i), {16'b0, mem_addr}, i);
      step();
      checkOutput($sformatf("b2b_rv%0d", i), {29'b0, if_gnt, mem_req, if_rvalid}, 32'h1);
      checkOutput($sformatf("b2b_data%0d", i), if_rdata, 32'hA000_0000 + i);
      if (i < 2) begin
        if_addr = 16'(i + 1);
      end else begin
        if_req = 1'b0;
      end
    end
    step();
    checkOutput("b2b_idle", {30'b0, if_gnt, mem_req}, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
